// File: rtl/bcd_sw_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One decade of the stopwatch count: clears, increments 0..9 and wraps.
module bcd_digit
  import bcd_sw_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic at_max
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear FSM, tick prescaler, BCD digit
// chain with ripple carry enables, lap snapshot and sticky overflow.
module bcd_stopwatch_ctrl
  import bcd_sw_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  running,
  output logic                  lap_hold,
  output logic                  overflow
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  sw_state_e             state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0]   snap_q, snap_d;
  logic                  overflow_q, overflow_d;
  logic [4*DIGITS-1:0]   count;
  logic [DIGITS-1:0]     at_max;
  logic [DIGITS-1:0]     inc_en;
  logic                  tick;
  logic                  clear_cnt;

  assign running   = (state_q == RUN) || (state_q == LAP);
  assign lap_hold  = (state_q == LAP);
  assign tick      = running && (presc_q == PRESC_LAST);
  assign clear_cnt = (state_q == PAUSE) && clear;

  // Clear outranks start_stop, which outranks lap; clear only acts in PAUSE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_stop) state_d = RUN;
      RUN: begin
        if (start_stop)  state_d = PAUSE;
        else if (lap)    state_d = LAP;
      end
      LAP: begin
        if (start_stop)  state_d = PAUSE;
        else if (lap)    state_d = RUN;
      end
      PAUSE: begin
        if (clear)           state_d = IDLE;
        else if (start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d    = presc_q;
    snap_d     = snap_q;
    overflow_d = overflow_q;
    if (clear_cnt) begin
      presc_d    = '0;
      overflow_d = 1'b0;
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && (&at_max)) overflow_d = 1'b1;
    end
    // Snapshot takes the pre-increment count of the cycle lap is sampled.
    if ((state_q == RUN) && !start_stop && lap) snap_d = count;
  end

  always_comb begin
    inc_en    = '0;
    inc_en[0] = tick;
    for (int i = 1; i < DIGITS; i++) begin
      inc_en[i] = inc_en[i-1] & at_max[i-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .clr    (clear_cnt),
      .inc    (inc_en[g]),
      .q      (count[4*g +: 4]),
      .at_max (at_max[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      snap_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      snap_q     <= snap_d;
      overflow_q <= overflow_d;
    end
  end

  assign disp_bcd = lap_hold ? snap_q : count;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with DIGITS=2, PRESCALE=4: a vector
// table of per-cycle expectations plus hand-written overflow and reset runs.
module tb_bcd_stopwatch_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [7:0] disp_bcd;
  logic       running;
  logic       lap_hold;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       ss;
    logic       clr;
    logic       lp;
    logic [7:0] disp;
    logic       run;
    logic       lh;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_hold   (lap_hold),
    .overflow   (overflow)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic r,
                           input logic lh, input logic ov);
    check_output({tag, " disp_bcd"}, 32'(disp_bcd), 32'(d));
    check_output({tag, " running"},  32'(running),  32'(r));
    check_output({tag, " lap_hold"}, 32'(lap_hold), 32'(lh));
    check_output({tag, " overflow"}, 32'(overflow), 32'(ov));
  endtask

  // Drive one cycle of pulses between edges, sample 1 time unit after the edge.
  task automatic apply_stimulus(input logic ss, input logic clr, input logic lp);
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    lap        = lp;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic ss, input logic clr, input logic lp,
                         input logic [7:0] d, input logic r, input logic lh, input logic ov);
    vec_t v;
    v.ss = ss; v.clr = clr; v.lp = lp;
    v.disp = d; v.run = r; v.lh = lh; v.ovf = ov;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n, input logic [7:0] d, input logic r,
                          input logic lh, input logic ov);
    for (int i = 0; i < n; i++) add_vec(1'b0, 1'b0, 1'b0, d, r, lh, ov);
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;

    // Step numbers count edges after the start_stop edge (step 0).
    add_vec (1, 0, 0, 8'h00, 1, 0, 0);      // 0  enter RUN
    add_idle(3,       8'h00, 1, 0, 0);      // 1-3
    add_idle(1,       8'h01, 1, 0, 0);      // 4  first tick
    add_idle(3,       8'h01, 1, 0, 0);      // 5-7
    add_idle(1,       8'h02, 1, 0, 0);      // 8
    add_idle(3,       8'h02, 1, 0, 0);
    add_idle(1,       8'h03, 1, 0, 0);      // 12
    add_idle(3,       8'h03, 1, 0, 0);
    add_idle(1,       8'h04, 1, 0, 0);      // 16
    add_idle(3,       8'h04, 1, 0, 0);
    add_idle(1,       8'h05, 1, 0, 0);      // 20
    add_vec (0, 0, 1, 8'h05, 1, 1, 0);      // 21 lap: freeze 05
    add_idle(11,      8'h05, 1, 1, 0);      // 22-32 count reaches 08 underneath
    add_vec (0, 0, 1, 8'h08, 1, 0, 0);      // 33 lap release, live 08
    add_idle(2,       8'h08, 1, 0, 0);      // 34-35
    add_idle(4,       8'h09, 1, 0, 0);      // 36-39
    add_idle(1,       8'h10, 1, 0, 0);      // 40 carry into digit 1
    add_idle(1,       8'h10, 1, 0, 0);      // 41 prescaler 1
    add_vec (1, 0, 0, 8'h10, 0, 0, 0);      // 42 pause, prescaler held at 2
    add_idle(2,       8'h10, 0, 0, 0);      // 43-44
    add_vec (1, 0, 0, 8'h10, 1, 0, 0);      // 45 resume
    add_idle(1,       8'h10, 1, 0, 0);      // 46 prescaler 3, tick
    add_idle(1,       8'h11, 1, 0, 0);      // 47 count updates
    add_vec (0, 1, 0, 8'h11, 1, 0, 0);      // 48 clear ignored in RUN
    add_vec (1, 0, 0, 8'h11, 0, 0, 0);      // 49 pause
    add_vec (1, 1, 0, 8'h00, 0, 0, 0);      // 50 clear beats start_stop -> IDLE
    add_vec (0, 1, 1, 8'h00, 0, 0, 0);      // 51 clear/lap ignored in IDLE
    add_idle(4,       8'h00, 0, 0, 0);      // 52-55 no ticks in IDLE
    add_vec (1, 0, 0, 8'h00, 1, 0, 0);      // 56 run with zeroed prescaler
    add_idle(3,       8'h00, 1, 0, 0);      // 57-59
    add_idle(1,       8'h01, 1, 0, 0);      // 60
    add_vec (1, 0, 1, 8'h01, 0, 0, 0);      // 61 start_stop beats lap -> PAUSE

    @(posedge clk);
    #1;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(3);
    check_all("idle after reset", 8'h00, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].ss, vecs[i].clr, vecs[i].lp);
      check_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].run, vecs[i].lh, vecs[i].ovf);
    end

    // Overflow: 99 after 396 cycles, wrap to 00 on the 100th tick, sticky after.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle_cycles(395);
    check_all("pre-99", 8'h98, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    check_all("at 99", 8'h99, 1'b1, 1'b0, 1'b0);
    idle_cycles(3);
    check_all("99 hold", 8'h99, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    check_all("wrap", 8'h00, 1'b1, 1'b0, 1'b1);
    idle_cycles(4);
    check_all("ovf sticky", 8'h01, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_all("ovf paused", 8'h01, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_all("ovf cleared", 8'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges while running.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle_cycles(8);
    check_all("pre-reset run", 8'h02, 1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_all("async reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(8);
    check_all("post-reset idle", 8'h00, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    check_all("post-reset tick", 8'h01, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Stopwatch controller that sequences a chain of BCD digit counters from a single clock. It owns the run/pause/lap/clear state machine, the tick prescaler and the digit-to-digit carry enables, and presents a live or frozen (lap) BCD display value to the seven-segment driver. It sits between the debounced push-button pulses and the display multiplexer.

## Interface
- DIGITS, 4, number of BCD digits in the chain (1..8); digit 0 is least significant
- PRESCALE, 1000, clk cycles per count tick (>= 2)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start_stop  in  1  one-cycle pulse, toggles run/pause
- clear  in  1  one-cycle pulse, zeroes the count (honoured only in PAUSE)
- lap  in  1  one-cycle pulse, freezes/releases the display while running
- disp_bcd  out  4*DIGITS  display value, digit i at [4i+3:4i]
- running  out  1  high in RUN and LAP
- lap_hold  out  1  high in LAP
- overflow  out  1  sticky, set when the chain wraps from all-9 to all-0

## Operation
- States: IDLE, RUN, PAUSE, LAP. Reset state IDLE.
- Input priority when pulses coincide: clear > start_stop > lap; lower-priority pulses in that cycle are dropped.
- IDLE: start_stop -> RUN. clear, lap ignored.
- RUN: start_stop -> PAUSE; lap -> LAP, snapshot register loaded with the current count. clear ignored.
- LAP: lap -> RUN (display returns to live); start_stop -> PAUSE (display returns to live). clear ignored.
- PAUSE: start_stop -> RUN; clear -> IDLE with count, prescaler and overflow zeroed.
- Prescaler counts 0..PRESCALE-1 only in RUN/LAP; holds value in PAUSE (fractional tick preserved); tick = running and prescaler == PRESCALE-1, prescaler wraps to 0 on that cycle.
- Digit i increments on tick when digits 0..i-1 are all 9; a digit at 9 that increments goes to 0. Each digit value is always 0..9.
- All digits 9 plus tick -> all digits 0, overflow set; overflow cleared only by clear or reset.
- disp_bcd = snapshot in LAP, live count otherwise.

## Timing
- Reset (async, immediate): state IDLE, count 0, prescaler 0, snapshot 0, disp_bcd 0, running 0, lap_hold 0, overflow 0.
- State, running, lap_hold change on the edge that samples the pulse (registered, one-cycle latency).
- First tick arrives PRESCALE cycles after the edge entering RUN from IDLE; count updates on that tick's edge.
- Snapshot captures the count value before any same-cycle increment.
- disp_bcd is a mux of registers: no combinational path from any input.
- Pulses held high longer than one cycle are treated as one pulse per cycle (no edge detection in this block).

## Structure
- Package bcd_sw_pkg: state enum (IDLE, RUN, PAUSE, LAP), BCD_MAX = 4'd9, bcd digit typedef (logic [3:0]).
- Sub-module bcd_digit: one digit with clk, reset (active-high async), clr, inc, q[3:0], at_max; instantiated DIGITS times via generate, carry enable = tick AND all lower at_max.
- FSM, prescaler and snapshot register live in the top module.

## Test plan (DIGITS=2, PRESCALE=4)
- Reset, start_stop pulse -> running=1 next edge; disp_bcd=8'h01 exactly 4 cycles after entering RUN, 8'h02 after 8.
- Run to 8'h09, next tick -> 8'h10 (carry into digit 1, digit 0 wraps to 0).
- Run to 8'h99, next tick -> 8'h00 with overflow=1; overflow stays 1 through further ticks until clear.
- At 8'h05 pulse lap -> lap_hold=1, disp_bcd holds 8'h05 while count advances; lap again at internal 8'h08 -> disp_bcd=8'h08, lap_hold=0.
- Pause mid-prescale (prescaler=2), resume -> next tick after 1 cycle; clear during RUN ignored; clear and start_stop same cycle in PAUSE -> IDLE, disp_bcd=8'h00, prescaler 0.
- Assert reset mid-RUN between edges -> all outputs 0 immediately, state IDLE after release; no tick until next start_stop.
